// File: rtl/cache_addr_seq_pkg.sv
// Shared defaults, state encoding and width helpers for the cache address
// sequencer and the arrays that reuse its decoders.
package cache_addr_seq_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_SET_BITS  = 6;
    localparam int DEF_WORD_BITS = 3;
    localparam int DEF_BYTE_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOK = 2'd1,
        ST_FILL = 2'd2
    } state_e;

    function automatic int tag_width(input int aw, input int sb, input int wb, input int bb);
        return aw - sb - wb - bb;
    endfunction

endpackage

// File: rtl/cache_addr_seq_onehot.sv
// Binary to one-hot decoder, shared by the set/offset decode and the arrays.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic [N-1:0]      bin,
    output logic [(2**N)-1:0] onehot
);

    // Single bit set at the binary index.
    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/cache_addr_seq.sv
// Address decode for single-cycle lookups plus a block-fill sequencer that
// issues every word of a missed block and decodes each returned word.
module cache_addr_seq
    import cache_addr_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SET_BITS  = DEF_SET_BITS,
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int BYTE_BITS = DEF_BYTE_BITS
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  logic                                         req_fill,
    input  logic [ADDR_W-1:0]                            req_addr,
    output logic                                         mem_req,
    output logic [ADDR_W-1:0]                            mem_addr,
    input  logic                                         mem_data_valid,
    output logic                                         out_valid,
    output logic [ADDR_W-SET_BITS-WORD_BITS-BYTE_BITS-1:0] out_tag,
    output logic [(2**SET_BITS)-1:0]                     out_set_onehot,
    output logic [(2**WORD_BITS)-1:0]                    out_offset_onehot,
    output logic                                         out_last,
    output logic                                         busy
);

    localparam int TAG_W = tag_width(ADDR_W, SET_BITS, WORD_BITS, BYTE_BITS);
    localparam int WORDS = 2**WORD_BITS;
    localparam int CNT_W = WORD_BITS + 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << (WORD_BITS + BYTE_BITS)) - 1);

    if (TAG_W < 1) begin : g_bad_tag
        $error("cache_addr_seq: address too narrow for set/word/byte fields");
    end

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [ADDR_W-1:0]       addr_r;
    logic [CNT_W-1:0]        issue_cnt_r;
    logic [CNT_W-1:0]        ret_cnt_r;
    logic                    accept_s;
    logic                    in_fill_s;
    logic                    fill_done_s;
    logic [ADDR_W-1:0]       fill_base_s;
    logic [WORD_BITS-1:0]    word_sel_s;
    logic [(2**SET_BITS)-1:0]  set_dec_s;
    logic [(2**WORD_BITS)-1:0] off_dec_s;

    assign in_fill_s   = (state_r == ST_FILL);
    assign req_ready   = ~in_fill_s;
    assign busy        = in_fill_s;
    assign accept_s    = req_valid & req_ready;
    assign fill_base_s = req_addr & ~LOW_MASK;
    assign fill_done_s = in_fill_s & mem_data_valid & (ret_cnt_r == CNT_W'(WORDS - 1));
    assign word_sel_s  = in_fill_s ? ret_cnt_r[WORD_BITS-1:0] : addr_r[BYTE_BITS +: WORD_BITS];

    onehot_dec #(.N(SET_BITS)) u_set_dec (
        .bin    (addr_r[BYTE_BITS+WORD_BITS +: SET_BITS]),
        .onehot (set_dec_s)
    );

    onehot_dec #(.N(WORD_BITS)) u_off_dec (
        .bin    (word_sel_s),
        .onehot (off_dec_s)
    );

    // Next-state selection; a new request may be taken from IDLE or LOOK.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_LOOK: begin
                if (accept_s) begin
                    state_nxt_s = req_fill ? ST_FILL : ST_LOOK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Issue strobe and word address; the offset field never carries out.
    always_comb begin
        mem_req  = in_fill_s & (issue_cnt_r < CNT_W'(WORDS));
        mem_addr = '0;
        if (mem_req) begin
            mem_addr = addr_r + (ADDR_W'(issue_cnt_r[WORD_BITS-1:0]) << BYTE_BITS);
        end else begin
            mem_addr = '0;
        end
    end

    // Decode outputs, forced to zero whenever out_valid is low.
    always_comb begin
        out_valid         = 1'b0;
        out_last          = 1'b0;
        out_tag           = '0;
        out_set_onehot    = '0;
        out_offset_onehot = '0;
        if (state_r == ST_LOOK) begin
            out_valid = 1'b1;
            out_last  = 1'b1;
        end else if (in_fill_s && mem_data_valid) begin
            out_valid = 1'b1;
            out_last  = fill_done_s;
        end else begin
            out_valid = 1'b0;
            out_last  = 1'b0;
        end
        if (out_valid) begin
            out_tag           = addr_r[ADDR_W-1 -: TAG_W];
            out_set_onehot    = set_dec_s;
            out_offset_onehot = off_dec_s;
        end else begin
            out_tag           = '0;
            out_set_onehot    = '0;
            out_offset_onehot = '0;
        end
    end

    // State, captured address and the two independent fill counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            issue_cnt_r <= '0;
            ret_cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r      <= req_fill ? fill_base_s : req_addr;
                issue_cnt_r <= '0;
                ret_cnt_r   <= '0;
            end else if (in_fill_s) begin
                if (mem_req) begin
                    issue_cnt_r <= issue_cnt_r + CNT_W'(1);
                end
                if (mem_data_valid) begin
                    ret_cnt_r <= ret_cnt_r + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_addr_seq.sv
// Self-checking bench for cache_addr_seq: lookup vectors, fill sequences,
// reset mid-fill, a reduced-parameter instance and randomized traffic.
module tb_cache_addr_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_fill, mem_data_valid;
    logic [15:0] req_addr;
    logic        req_ready, mem_req, out_valid, out_last, busy;
    logic [15:0] mem_addr;
    logic [5:0]  out_tag;
    logic [63:0] out_set_onehot;
    logic [7:0]  out_offset_onehot;

    logic        v_req_valid, v_req_fill, v_mdv;
    logic [15:0] v_req_addr;
    logic        v_req_ready, v_mem_req, v_out_valid, v_out_last, v_busy;
    logic [15:0] v_mem_addr;
    logic [8:0]  v_out_tag;
    logic [15:0] v_out_set;
    logic [3:0]  v_out_off;

    cache_addr_seq dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_fill(req_fill), .req_addr(req_addr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .out_valid(out_valid), .out_tag(out_tag),
        .out_set_onehot(out_set_onehot), .out_offset_onehot(out_offset_onehot),
        .out_last(out_last), .busy(busy)
    );

    cache_addr_seq #(.ADDR_W(16), .SET_BITS(4), .WORD_BITS(2), .BYTE_BITS(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .req_valid(v_req_valid), .req_ready(v_req_ready),
        .req_fill(v_req_fill), .req_addr(v_req_addr), .mem_req(v_mem_req), .mem_addr(v_mem_addr),
        .mem_data_valid(v_mdv), .out_valid(v_out_valid), .out_tag(v_out_tag),
        .out_set_onehot(v_out_set), .out_offset_onehot(v_out_off),
        .out_last(v_out_last), .busy(v_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what is pending, in plain counts and addresses.
    bit          m_look  = 1'b0;
    bit          m_fill  = 1'b0;
    int          m_iss   = 0;
    int          m_ret   = 0;
    int unsigned m_laddr = 0;
    int unsigned m_base  = 0;

    task automatic settle();
        bit          e_valid, e_last, e_req;
        int unsigned e_tag, e_addr;
        logic [63:0] e_set;
        logic [7:0]  e_off;
        #4;
        e_valid = 1'b0; e_last = 1'b0; e_tag = 0; e_set = '0; e_off = '0;
        e_req  = m_fill && (m_iss < 8);
        e_addr = e_req ? (m_base + 2 * m_iss) : 0;
        if (m_look) begin
            e_valid = 1'b1; e_last = 1'b1;
            e_tag = m_laddr / 1024;
            e_set = 64'd1 << ((m_laddr / 16) % 64);
            e_off = 8'd1 << ((m_laddr / 2) % 8);
        end else if (m_fill && mem_data_valid) begin
            e_valid = 1'b1; e_last = (m_ret == 7);
            e_tag = m_base / 1024;
            e_set = 64'd1 << ((m_base / 16) % 64);
            e_off = 8'd1 << m_ret;
        end
        check("m_ready", req_ready, !m_fill);
        check("m_busy", busy, m_fill);
        check("m_mem_req", mem_req, e_req);
        check("m_mem_addr", mem_addr, e_addr);
        check("m_valid", out_valid, e_valid);
        check("m_last", out_last, e_last);
        check("m_tag", out_tag, e_tag);
        check("m_set", out_set_onehot, e_set);
        check("m_off", out_offset_onehot, e_off);
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (!rst_n) begin
            m_look = 1'b0; m_fill = 1'b0; m_iss = 0; m_ret = 0;
        end else begin
            bit acc;
            acc    = req_valid && !m_fill;
            m_look = 1'b0;
            if (m_fill) begin
                if (m_iss < 8) m_iss++;
                if (mem_data_valid) begin
                    m_ret++;
                    if (m_ret == 8) m_fill = 1'b0;
                end
            end
            if (acc && req_fill) begin
                m_fill = 1'b1; m_base = req_addr & 16'hFFF0; m_iss = 0; m_ret = 0;
            end else if (acc) begin
                m_look = 1'b1; m_laddr = req_addr;
            end
        end
        #1;
    endtask

    // mode 0: each word returns 4 cycles after issue; mode 1: every other cycle.
    task automatic run_fill(input logic [15:0] addr, input int mode, input bit hold_lookup);
        bit [15:0] pipe;
        int pulses, issues, cyc;
        bit done;
        pipe = '0; pulses = 0; issues = 0; cyc = 0; done = 1'b0;
        req_valid = 1'b1; req_fill = 1'b1; req_addr = addr; mem_data_valid = 1'b0;
        settle();
        edge_step();
        if (hold_lookup) begin
            req_fill = 1'b0; req_addr = 16'hA5F6;
        end else begin
            req_valid = 1'b0;
        end
        while (!done && cyc < 60) begin
            mem_data_valid = (mode == 0) ? pipe[3] : cyc[0];
            settle();
            check("fill_ready_low", req_ready, 1'b0);
            if (mem_req) begin
                check("fill_addr", mem_addr, (addr & 16'hFFF0) + issues * 2);
                issues++;
            end
            if (out_valid) begin
                check("fill_off", out_offset_onehot, 8'd1 << pulses);
                pulses++;
                if (out_last) done = 1'b1;
            end
            pipe = {pipe[14:0], mem_req};
            edge_step();
            cyc++;
        end
        mem_data_valid = 1'b0;
        check("fill_done", done, 1'b1);
        check("fill_issues", issues, 8);
        check("fill_pulses", pulses, 8);
        settle();
        check("ready_after_last", req_ready, 1'b1);
        edge_step();
        if (hold_lookup) begin
            req_valid = 1'b0;
            settle();
            check("held_lookup_valid", out_valid, 1'b1);
            check("held_lookup_tag", out_tag, 6'h29);
            edge_step();
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [5:0]  tag;
        logic [63:0] set;
        logic [7:0]  off;
    } lk_vec_t;

    lk_vec_t tbl [3];

    initial begin
        tbl[0] = '{16'hA5F6, 6'h29, 64'h0000_0000_8000_0000, 8'h08};
        tbl[1] = '{16'h0000, 6'h00, 64'h0000_0000_0000_0001, 8'h01};
        tbl[2] = '{16'hFFFE, 6'h3F, 64'h8000_0000_0000_0000, 8'h80};

        rst_n = 1'b0; req_valid = 1'b0; req_fill = 1'b0; req_addr = '0; mem_data_valid = 1'b0;
        v_req_valid = 1'b0; v_req_fill = 1'b0; v_req_addr = '0; v_mdv = 1'b0;
        edge_step();
        edge_step();
        settle();
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        edge_step();

        // Back-to-back lookups; result i is visible while request i+1 is driven.
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) begin
                req_valid = 1'b1; req_fill = 1'b0; req_addr = tbl[i].addr;
            end else begin
                req_valid = 1'b0;
            end
            settle();
            if (i > 0) begin
                check("tbl_valid", out_valid, 1'b1);
                check("tbl_last", out_last, 1'b1);
                check("tbl_tag", out_tag, tbl[i-1].tag);
                check("tbl_set", out_set_onehot, tbl[i-1].set);
                check("tbl_off", out_offset_onehot, tbl[i-1].off);
            end
            edge_step();
        end
        settle();
        check("lookup_one_cycle", out_valid, 1'b0);
        edge_step();

        run_fill(16'h1236, 0, 1'b1);
        run_fill(16'h7F3C, 1, 1'b0);

        mem_data_valid = 1'b1;
        settle();
        check("stray_mdv_idle", out_valid, 1'b0);
        edge_step();
        mem_data_valid = 1'b0;

        // Reset after three returned words.
        req_valid = 1'b1; req_fill = 1'b1; req_addr = 16'h2468;
        settle();
        edge_step();
        req_valid = 1'b0; mem_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            edge_step();
        end
        rst_n = 1'b0;
        settle();
        edge_step();
        rst_n = 1'b1;
        settle();
        check("rst_fill_mem_req", mem_req, 1'b0);
        check("rst_fill_busy", busy, 1'b0);
        check("rst_fill_valid", out_valid, 1'b0);
        check("rst_fill_ready", req_ready, 1'b1);
        edge_step();
        mem_data_valid = 1'b0;
        run_fill(16'h2468, 0, 1'b0);

        // Reduced-parameter instance: 4 words per block, 16 sets.
        begin
            int v_iss, v_pulses;
            bit v_last;
            v_iss = 0; v_pulses = 0; v_last = 1'b0;
            v_req_valid = 1'b1; v_req_fill = 1'b1; v_req_addr = 16'h0078;
            edge_step();
            v_req_valid = 1'b0; v_mdv = 1'b1;
            for (int c = 0; c < 10; c++) begin
                #4;
                if (v_mem_req) begin
                    check("small_addr", v_mem_addr, 16'h0078 + v_iss * 2);
                    v_iss++;
                end
                if (v_out_valid) begin
                    check("small_set", v_out_set, 16'h8000);
                    check("small_off", v_out_off, 4'd1 << v_pulses);
                    v_pulses++;
                    if (v_out_last) v_last = 1'b1;
                end
                edge_step();
            end
            v_mdv = 1'b0;
            check("small_issues", v_iss, 4);
            check("small_pulses", v_pulses, 4);
            check("small_last", v_last, 1'b1);
            check("small_idle", v_busy, 1'b0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst_n          = ($urandom_range(99) != 0);
            req_valid      = $urandom_range(1);
            req_fill       = ($urandom_range(3) == 0);
            req_addr       = 16'($urandom);
            mem_data_valid = $urandom_range(1);
            settle();
            edge_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
